// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control codes, ALUOp and funct encodings, FSM state type
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SLT = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SRA = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;
   localparam logic [3:0] ALU_DIV = 4'd9;

   localparam logic [1:0] ALUOP_FUNCT = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_SLT   = 2'b10;
   localparam logic [1:0] ALUOP_ADD   = 2'b11;

   localparam int F_ADD = 0;
   localparam int F_SUB = 1;
   localparam int F_AND = 2;
   localparam int F_OR  = 3;
   localparam int F_SLT = 4;
   localparam int F_SLL = 5;
   localparam int F_SRL = 6;
   localparam int F_SRA = 7;
   localparam int F_JR  = 8;
   localparam int F_MUL = 9;
   localparam int F_DIV = 10;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE   = 1'b0;
   localparam state_t ST_MD_RUN = 1'b1;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational ALUOp/funct decode; shifts enabled by ALU_CTRL_SHIFT_EN
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int FUNC_W = 6,
   parameter int CTRL_W = 4
) (
   input  logic [1:0]        alu_op,
   input  logic [FUNC_W-1:0] funct,
   output logic [CTRL_W-1:0] code,
   output logic              jr
);

   logic [3:0] code4;

   always_comb begin
      code4 = ALU_ADD;
      jr    = 1'b0;
      case (alu_op)
         ALUOP_ADD: code4 = ALU_ADD;
         ALUOP_SUB: code4 = ALU_SUB;
         ALUOP_SLT: code4 = ALU_SLT;
         default: begin
            case (funct)
               FUNC_W'(F_ADD): code4 = ALU_ADD;
               FUNC_W'(F_SUB): code4 = ALU_SUB;
               FUNC_W'(F_AND): code4 = ALU_AND;
               FUNC_W'(F_OR):  code4 = ALU_OR;
               FUNC_W'(F_SLT): code4 = ALU_SLT;
`ifdef ALU_CTRL_SHIFT_EN
               FUNC_W'(F_SLL): code4 = ALU_SLL;
               FUNC_W'(F_SRL): code4 = ALU_SRL;
               FUNC_W'(F_SRA): code4 = ALU_SRA;
`endif
               FUNC_W'(F_JR): begin
                  code4 = ALU_ADD;
                  jr    = 1'b1;
               end
               FUNC_W'(F_MUL): code4 = ALU_MUL;
               FUNC_W'(F_DIV): code4 = ALU_DIV;
               default:        code4 = ALU_ADD;
            endcase
         end
      endcase
   end

   assign code = CTRL_W'(code4);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// rtl/alu_ctrl_pipe.sv - EX-stage ALU control register with multiply/divide busy FSM
// Optional shift decode via macro ALU_CTRL_SHIFT_EN (see alu_ctrl_decode).
module alu_ctrl_pipe
   import alu_ctrl_pkg::*;
#(
   parameter int FUNC_W = 6,
   parameter int CTRL_W = 4,
   parameter int MD_LAT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic [1:0]        alu_op,
   input  logic [FUNC_W-1:0] funct,
   input  logic              stall,
   input  logic              flush,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic              jr_ctrl,
   output logic              valid_out,
   output logic              md_busy,
   output logic              stall_req
);

   localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

   logic [CTRL_W-1:0] dec_code;
   logic              dec_jr;
   logic              is_md;
   logic              accept;
   state_t            state;
   logic [CNT_W-1:0]  cnt;

   alu_ctrl_decode #(
      .FUNC_W (FUNC_W),
      .CTRL_W (CTRL_W)
   ) u_decode (
      .alu_op (alu_op),
      .funct  (funct),
      .code   (dec_code),
      .jr     (dec_jr)
   );

   assign is_md  = (dec_code == CTRL_W'(ALU_MUL)) || (dec_code == CTRL_W'(ALU_DIV));
   // The edge that leaves MD_RUN also accepts a new instruction, so ops run back to back.
   assign accept = (state == ST_IDLE) || (cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         alu_ctrl  <= '0;
         jr_ctrl   <= 1'b0;
         valid_out <= 1'b0;
      end else if (flush) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         alu_ctrl  <= '0;
         jr_ctrl   <= 1'b0;
         valid_out <= 1'b0;
      end else if (!accept) begin
         cnt <= cnt - 1'b1;
      end else if (stall) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (valid_in) begin
         alu_ctrl  <= dec_code;
         jr_ctrl   <= dec_jr;
         valid_out <= 1'b1;
         if (is_md) begin
            state <= ST_MD_RUN;
            cnt   <= CNT_W'(MD_LAT - 1);
         end else begin
            state <= ST_IDLE;
            cnt   <= '0;
         end
      end else begin
         state     <= ST_IDLE;
         cnt       <= '0;
         alu_ctrl  <= '0;
         jr_ctrl   <= 1'b0;
         valid_out <= 1'b0;
      end
   end

   assign md_busy   = (state == ST_MD_RUN);
   assign stall_req = md_busy;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb/tb_alu_ctrl_pipe.sv - directed-vector bench with a behavioural model for alu_ctrl_pipe
module tb_alu_ctrl_pipe;

   localparam int FUNC_W = 6;
   localparam int CTRL_W = 4;
   localparam int MD_LAT = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              valid_in = 1'b0;
   logic [1:0]        alu_op = 2'b00;
   logic [FUNC_W-1:0] funct = '0;
   logic              stall = 1'b0;
   logic              flush = 1'b0;
   logic [CTRL_W-1:0] alu_ctrl;
   logic              jr_ctrl;
   logic              valid_out;
   logic              md_busy;
   logic              stall_req;

   int checks = 0;
   int failures = 0;

   alu_ctrl_pipe #(
      .FUNC_W (FUNC_W),
      .CTRL_W (CTRL_W),
      .MD_LAT (MD_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .alu_op    (alu_op),
      .funct     (funct),
      .stall     (stall),
      .flush     (flush),
      .alu_ctrl  (alu_ctrl),
      .jr_ctrl   (jr_ctrl),
      .valid_out (valid_out),
      .md_busy   (md_busy),
      .stall_req (stall_req)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode straight from the opcode table.
   function automatic int ref_code(input int op, input int f, output bit jr);
      jr = 0;
      if (op == 3) return 0;
      if (op == 1) return 1;
      if (op == 2) return 4;
      if (f <= 4) return f;
`ifdef ALU_CTRL_SHIFT_EN
      if (f >= 5 && f <= 7) return f;
`endif
      if (f == 8) begin
         jr = 1;
         return 0;
      end
      if (f == 9) return 8;
      if (f == 10) return 9;
      return 0;
   endfunction

   // Model: busy_left counts remaining busy cycles, outputs are held while more than one remains.
   int e_ctrl = 0;
   bit e_jr = 0;
   bit e_valid = 0;
   int busy_left = 0;
   bit started = 0;

   always @(posedge clk) begin
      int c;
      bit j;
      if (!rst_n) begin
         e_ctrl = 0; e_jr = 0; e_valid = 0; busy_left = 0;
         started = 1;
      end else if (flush) begin
         e_ctrl = 0; e_jr = 0; e_valid = 0; busy_left = 0;
      end else if (busy_left > 1) begin
         busy_left = busy_left - 1;
      end else begin
         busy_left = 0;
         if (!stall) begin
            if (valid_in) begin
               c = ref_code(int'(alu_op), int'(funct), j);
               e_ctrl = c; e_jr = j; e_valid = 1;
               if (c == 8 || c == 9) busy_left = MD_LAT;
            end else begin
               e_ctrl = 0; e_jr = 0; e_valid = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("valid_out", int'(valid_out), int'(e_valid));
         check("alu_ctrl", int'(alu_ctrl), e_ctrl);
         check("md_busy", int'(md_busy), int'(busy_left > 0));
         check("stall_req", int'(stall_req), int'(busy_left > 0));
         if (e_valid) check("jr_ctrl", int'(jr_ctrl), int'(e_jr));
      end
   end

   task automatic drive(input bit v, input int op, input int f, input bit st, input bit fl);
      valid_in = v;
      alu_op   = 2'(op);
      funct    = FUNC_W'(f);
      stall    = st;
      flush    = fl;
      @(negedge clk);
   endtask

   initial begin
      int nb;
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      check("lit_reset_valid", int'(valid_out), 0);
      check("lit_reset_ctrl", int'(alu_ctrl), 0);
      check("lit_reset_busy", int'(md_busy), 0);
      rst_n = 1'b1;

      drive(1, 0, 3, 0, 0);
      check("lit_or_ctrl", int'(alu_ctrl), 3);
      check("lit_or_valid", int'(valid_out), 1);
      check("lit_or_jr", int'(jr_ctrl), 0);

      drive(1, 0, 8, 0, 0);
      check("lit_jr_ctrl", int'(alu_ctrl), 0);
      check("lit_jr_jr", int'(jr_ctrl), 1);
      drive(1, 3, 9, 0, 0);
      check("lit_addi_ctrl", int'(alu_ctrl), 0);
      check("lit_addi_busy", int'(md_busy), 0);
      drive(1, 2, 1, 0, 0);
      check("lit_slti_ctrl", int'(alu_ctrl), 4);
      drive(1, 1, 2, 0, 0);
      check("lit_beq_ctrl", int'(alu_ctrl), 1);

      for (int f = 0; f < 12; f++) begin
         if (f != 9 && f != 10) drive(1, 0, f, 0, 0);
      end
      drive(1, 0, 63, 0, 0);
      drive(1, 0, 6, 0, 0);
`ifdef ALU_CTRL_SHIFT_EN
      check("lit_srl_ctrl", int'(alu_ctrl), 6);
`else
      check("lit_srl_ctrl", int'(alu_ctrl), 0);
`endif
      drive(0, 0, 2, 0, 0);
      check("lit_bubble_valid", int'(valid_out), 0);
      check("lit_bubble_ctrl", int'(alu_ctrl), 0);

      // Multiply: inputs and stall during busy cycles must be ignored.
      drive(1, 0, 9, 0, 0);
      check("lit_mul_ctrl", int'(alu_ctrl), 8);
      nb = md_busy ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 2, i[0], 0);
         if (md_busy) nb++;
         check("lit_mul_hold", int'(alu_ctrl), 8);
      end
      drive(1, 0, 4, 0, 0);
      if (md_busy) nb++;
      check("lit_mul_busy_cycles", nb, 4);
      check("lit_after_mul_ctrl", int'(alu_ctrl), 4);

      // Back-to-back multiply then divide.
      drive(1, 0, 9, 0, 0);
      for (int i = 0; i < 3; i++) drive(1, 0, 10, 0, 0);
      drive(1, 0, 10, 0, 0);
      check("lit_b2b_busy", int'(md_busy), 1);
      check("lit_b2b_ctrl", int'(alu_ctrl), 9);
      for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 0);
      check("lit_b2b_end_ctrl", int'(alu_ctrl), 1);

      // Divide aborted by flush on busy cycle 2.
      drive(1, 0, 10, 0, 0);
      drive(1, 0, 2, 0, 0);
      drive(1, 0, 2, 0, 1);
      check("lit_flush_busy", int'(md_busy), 0);
      check("lit_flush_stall_req", int'(stall_req), 0);
      check("lit_flush_valid", int'(valid_out), 0);
      drive(1, 0, 0, 0, 0);
      check("lit_post_flush_valid", int'(valid_out), 1);
      check("lit_post_flush_ctrl", int'(alu_ctrl), 0);

      // Stall holds; flush beats stall.
      drive(1, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(1, 0, 3, 1, 0);
      check("lit_stall_ctrl", int'(alu_ctrl), 1);
      check("lit_stall_valid", int'(valid_out), 1);
      drive(1, 0, 3, 1, 1);
      check("lit_stall_flush_valid", int'(valid_out), 0);

      // Reset in the middle of a multiply.
      drive(1, 0, 9, 0, 0);
      drive(1, 0, 9, 0, 0);
      rst_n = 1'b0;
      drive(1, 0, 9, 0, 0);
      check("lit_rst_md_busy", int'(md_busy), 0);
      check("lit_rst_md_valid", int'(valid_out), 0);
      rst_n = 1'b1;
      drive(1, 0, 2, 0, 0);
      check("lit_rst_recover_ctrl", int'(alu_ctrl), 2);
      drive(0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
